// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation set, ALU class
// encodings coming from decode, branch func3 codes and the ALU decoder.
package execute_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_fn_e;

  // alu_op classes driven by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // Branch condition codes (func3 of B-type)
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Map alu_op/func3/bit30 to an ALU operation. For I-type, bit30 is part of
  // the immediate except on the shift-right encoding, so it is only honoured
  // there (ADDI with a negative immediate must not become SUB).
  function automatic alu_fn_e decode_alu(input logic [1:0] alu_op,
                                         input logic [2:0] func3,
                                         input logic       func7b5);
    alu_fn_e fn;
    logic    alt;
    alt = func7b5 && (alu_op == ALUOP_RTYPE || func3 == 3'b101);
    case (func3)
      3'b000:  fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  fn = ALU_SLL;
      3'b010:  fn = ALU_SLT;
      3'b011:  fn = ALU_SLTU;
      3'b100:  fn = ALU_XOR;
      3'b101:  fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  fn = ALU_OR;
      default: fn = ALU_AND;
    endcase
    case (alu_op)
      ALUOP_ADD: fn = ALU_ADD;
      ALUOP_SUB: fn = ALU_SUB;
      default:   ;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational integer ALU. Shift amount is b[5:0]; compares return 0/1.
module alu import execute_stage_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_fn_e         op,
  output logic [XLEN-1:0] result
);

  logic [5:0] shamt;
  assign shamt = b[5:0];

  // Operation select
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register. Controls are squashed on flush; data still loads so a
// flushed slot carries harmless values.
module execute_stage import execute_stage_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] immediate,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            branch,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic            alu_src,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      func3,
  input  logic            func7b5,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] alu_result_d3,
  output logic [XLEN-1:0] store_data_d3,
  output logic [XLEN-1:0] branch_target_d3,
  output logic [4:0]      rd_d3,
  output logic [2:0]      func3_d3,
  output logic            mem_read_d3,
  output logic            mem_write_d3,
  output logic            mem_to_reg_d3,
  output logic            reg_write_d3,
  output logic            branch_taken_d3
);

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_y;
  logic            br_cond;
  logic            ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
  alu_fn_e         alu_fn;

  // A load in EX/MEM has no data yet, so it is excluded as a source.
  assign ex_hit_a = reg_write_d3 && !mem_read_d3 && rd_d3 != 5'd0 && rd_d3 == rs1;
  assign ex_hit_b = reg_write_d3 && !mem_read_d3 && rd_d3 != 5'd0 && rd_d3 == rs2;
  assign wb_hit_a = wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1;
  assign wb_hit_b = wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2;

  // Forwarding muxes: the younger EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_a = rs1_data;
    if (ex_hit_a)      fwd_a = alu_result_d3;
    else if (wb_hit_a) fwd_a = wb_data;
    fwd_b = rs2_data;
    if (ex_hit_b)      fwd_b = alu_result_d3;
    else if (wb_hit_b) fwd_b = wb_data;
  end

  assign op_b   = alu_src ? immediate : fwd_b;
  assign alu_fn = decode_alu(alu_op, func3, func7b5);

  alu #(.XLEN(XLEN)) u_alu (
    .a      (fwd_a),
    .b      (op_b),
    .op     (alu_fn),
    .result (alu_y)
  );

  // Branch condition on forwarded register values (never the immediate)
  always_comb begin
    br_cond = 1'b0;
    case (func3)
      BR_EQ:   br_cond = (fwd_a == fwd_b);
      BR_NE:   br_cond = (fwd_a != fwd_b);
      BR_LT:   br_cond = ($signed(fwd_a) <  $signed(fwd_b));
      BR_GE:   br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  br_cond = (fwd_a <  fwd_b);
      BR_GEU:  br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  // EX/MEM register: stall holds, flush zeroes controls but lets data load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_d3    <= '0;
      store_data_d3    <= '0;
      branch_target_d3 <= '0;
      rd_d3            <= '0;
      func3_d3         <= '0;
      mem_read_d3      <= 1'b0;
      mem_write_d3     <= 1'b0;
      mem_to_reg_d3    <= 1'b0;
      reg_write_d3     <= 1'b0;
      branch_taken_d3  <= 1'b0;
    end else begin
      if (!stall || flush) begin
        alu_result_d3    <= alu_y;
        store_data_d3    <= fwd_b;
        branch_target_d3 <= pc + immediate;
        rd_d3            <= rd;
        func3_d3         <= func3;
      end
      if (flush) begin
        mem_read_d3     <= 1'b0;
        mem_write_d3    <= 1'b0;
        mem_to_reg_d3   <= 1'b0;
        reg_write_d3    <= 1'b0;
        branch_taken_d3 <= 1'b0;
      end else if (!stall) begin
        mem_read_d3     <= mem_read;
        mem_write_d3    <= mem_write;
        mem_to_reg_d3   <= mem_to_reg;
        reg_write_d3    <= reg_write;
        branch_taken_d3 <= branch && br_cond;
      end
    end
  end

endmodule
